// File: rtl/i2c_eeprom_slave.sv
`timescale 1ns/1ps
// I2C slave emulating a 24C02-style EEPROM with an 8-bit word pointer.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low via sda_oe_o.
module i2c_eeprom_slave #(
  parameter logic [6:0] ADDRESS   = 7'b1010000,
  parameter int         MEM_DEPTH = 256,
  parameter int         PAGE_SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);
  localparam logic [7:0] PTR_MAX   = 8'(MEM_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       rw_q, rw_d;
  logic       byte_rdy_q, byte_rdy_d;
  logic       mem_we;
  logic [7:0] rd_byte, ptr_inc_page, ptr_inc_lin;
  logic [7:0] mem_q [MEM_DEPTH];

  // Two-flop synchronizers plus a previous-value stage; reset to idle bus (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rd_byte      = mem_q[ptr_q];
  // Writes wrap inside the current page; reads walk the whole array.
  assign ptr_inc_page = (ptr_q & ~PAGE_MASK) | ((ptr_q + 8'd1) & PAGE_MASK);
  assign ptr_inc_lin  = (ptr_q == PTR_MAX) ? 8'd0 : ptr_q + 8'd1;

  // Protocol FSM: bits captured on SCL rise, SDA drive changes only on SCL fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    rw_d       = rw_q;
    byte_rdy_d = byte_rdy_q;
    mem_we     = 1'b0;
    if (start_c) begin
      state_d    = DEV_ADDR;
      bit_cnt_d  = 3'd0;
      byte_rdy_d = 1'b0;
      oe_d       = 1'b0;
    end else if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      byte_rdy_d = 1'b0;
      oe_d       = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          shreg_d   = {shreg_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_rdy_d = 1'b1;
        end
        RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_rdy_d = 1'b1;
        end
        RD_ACK: begin
          if (sda_s) state_d = IDLE;
          else       ptr_d   = ptr_inc_lin;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        DEV_ADDR: if (byte_rdy_q) begin
          byte_rdy_d = 1'b0;
          if (shreg_q[7:1] == ADDRESS) begin
            oe_d    = 1'b1;
            rw_d    = shreg_q[0];
            state_d = DEV_ACK;
          end else begin
            state_d = IDLE;
          end
        end
        DEV_ACK: begin
          bit_cnt_d = 3'd0;
          if (rw_q) begin
            state_d = RD_DATA;
            shreg_d = rd_byte;
            oe_d    = ~rd_byte[7];
          end else begin
            state_d = WORD_ADDR;
            oe_d    = 1'b0;
          end
        end
        WORD_ADDR: if (byte_rdy_q) begin
          byte_rdy_d = 1'b0;
          ptr_d      = shreg_q;
          oe_d       = 1'b1;
          state_d    = WORD_ACK;
        end
        WR_DATA: if (byte_rdy_q) begin
          byte_rdy_d = 1'b0;
          mem_we     = 1'b1;
          ptr_d      = ptr_inc_page;
          oe_d       = 1'b1;
          state_d    = WR_ACK;
        end
        WORD_ACK, WR_ACK: begin
          oe_d      = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = WR_DATA;
        end
        RD_DATA: begin
          if (byte_rdy_q) begin
            byte_rdy_d = 1'b0;
            oe_d       = 1'b0;
            state_d    = RD_ACK;
          end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
            oe_d    = ~shreg_q[6];
          end
        end
        RD_ACK: begin
          // Only reachable after a master ACK; ptr already advanced on the rise.
          bit_cnt_d = 3'd0;
          state_d   = RD_DATA;
          shreg_d   = rd_byte;
          oe_d      = ~rd_byte[7];
        end
        default: ;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'd0;
      ptr_q      <= 8'd0;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      byte_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      byte_rdy_q <= byte_rdy_d;
    end
  end

  // Storage array; contents survive reset like a real EEPROM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= shreg_q;
  end

  assign sda_oe_o = oe_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
// Bench: bit-banged I2C master plus a transaction-level EEPROM model.
module tb_i2c_eeprom_slave;

  localparam int H = 6;  // clk cycles per SCL phase slice

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe;
  logic sda_bus;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_m [256];
  bit         known [256];
  int         ptr_m = 0;
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe_o (sda_oe)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void m_write(input int addr, input int n);
    int p = addr;
    for (int i = 0; i < n; i++) begin
      mem_m[p] = wbuf[i];
      known[p] = 1'b1;
      p = (p / 16) * 16 + (p + 1) % 16;
    end
    ptr_m = p;
  endfunction

  function automatic logic [7:0] m_read();
    logic [7:0] v = mem_m[ptr_m];
    ptr_m = (ptr_m + 1) % 256;
    return v;
  endfunction

  // ---------------- bus primitives ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clks(H);
    scl = 1'b1;   wait_clks(H);
    m_sda = 1'b0; wait_clks(H);
    scl = 1'b0;   wait_clks(H);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clks(H);
    scl = 1'b1;   wait_clks(H);
    m_sda = 1'b1; wait_clks(H);
  endtask

  task automatic put_bits(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b; wait_clks(H);
      scl = 1'b1; wait_clks(H);
      scl = 1'b0; wait_clks(H);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_clks(H);
      scl = 1'b1;   wait_clks(H);
      scl = 1'b0;   wait_clks(H);
    end
    m_sda = 1'b1; wait_clks(H);
    scl = 1'b1;   wait_clks(3);
    ack = sda_oe;
    wait_clks(H - 3);
    scl = 1'b0;   wait_clks(H);
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(H);
      scl = 1'b1; wait_clks(3);
      b[i] = sda_bus;
      wait_clks(H - 3);
      scl = 1'b0;
    end
    m_sda = ~mack; wait_clks(H);
    scl = 1'b1;    wait_clks(H);
    scl = 1'b0;    m_sda = 1'b1; wait_clks(H);
  endtask

  task automatic wr_txn(input logic [7:0] addr, input int n, output int nacks);
    logic a;
    nacks = 0;
    bus_start();
    put_byte(8'hA0, a); if (!a) nacks++;
    put_byte(addr, a);  if (!a) nacks++;
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], a); if (!a) nacks++;
    end
    bus_stop();
  endtask

  task automatic rd_txn(input logic [7:0] addr, input bit set_addr, input int n, output int nacks);
    logic a;
    logic [7:0] b;
    nacks = 0;
    bus_start();
    if (set_addr) begin
      put_byte(8'hA0, a); if (!a) nacks++;
      put_byte(addr, a);  if (!a) nacks++;
      bus_start();
    end
    put_byte(8'hA1, a); if (!a) nacks++;
    for (int i = 0; i < n; i++) begin
      get_byte(i < n - 1, b);
      rbuf[i] = b;
    end
    bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    wait_clks(4);
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", sda_oe); end
    rst = 1'b0;
    ptr_m = 0;
    wait_clks(8);
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL post_reset_oe: got %b expected 0", sda_oe); end
  endtask

  task automatic test_write_read();
    int nk;
    logic [7:0] exp;
    wbuf[0] = 8'h5A;
    wr_txn(8'h10, 1, nk);
    m_write(8'h10, 1);
    checks++;
    if (nk != 0) begin failures++; $display("FAIL basic_write_acks: missing %0d expected 0", nk); end
    rd_txn(8'h10, 1'b1, 1, nk);
    ptr_m = 8'h10;
    exp = m_read();
    checks++;
    if (nk != 0) begin failures++; $display("FAIL basic_read_acks: missing %0d expected 0", nk); end
    checks++;
    if (rbuf[0] !== exp) begin failures++; $display("FAIL basic_read_data: got %h expected %h", rbuf[0], exp); end
    wait_clks(4);
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL basic_stop_oe: got %b expected 0", sda_oe); end
  endtask

  task automatic test_seq_wrap();
    int nk;
    logic [7:0] exp;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(8'hFE, 2, nk); m_write(8'hFE, 2);
    checks++;
    if (nk != 0) begin failures++; $display("FAIL seq_preload_hi: missing %0d expected 0", nk); end
    wbuf[0] = 8'h33;
    wr_txn(8'h00, 1, nk); m_write(8'h00, 1);
    checks++;
    if (nk != 0) begin failures++; $display("FAIL seq_preload_lo: missing %0d expected 0", nk); end
    rd_txn(8'hFE, 1'b1, 3, nk);
    ptr_m = 8'hFE;
    checks++;
    if (nk != 0) begin failures++; $display("FAIL seq_read_acks: missing %0d expected 0", nk); end
    for (int i = 0; i < 3; i++) begin
      exp = m_read();
      checks++;
      if (rbuf[i] !== exp) begin failures++; $display("FAIL seq_wrap_byte%0d: got %h expected %h", i, rbuf[i], exp); end
    end
  endtask

  task automatic test_page_wrap();
    int nk;
    logic [7:0] exp;
    logic [7:0] addrs [3];
    addrs[0] = 8'h0F; addrs[1] = 8'h00; addrs[2] = 8'h10;
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    wr_txn(8'h0F, 2, nk); m_write(8'h0F, 2);
    checks++;
    if (nk != 0) begin failures++; $display("FAIL page_write_acks: missing %0d expected 0", nk); end
    for (int i = 0; i < 3; i++) begin
      rd_txn(addrs[i], 1'b1, 1, nk);
      ptr_m = int'(addrs[i]);
      exp = m_read();
      checks++;
      if (rbuf[0] !== exp || nk != 0) begin
        failures++;
        $display("FAIL page_wrap_@%h: got %h (nacks %0d) expected %h", addrs[i], rbuf[0], nk, exp);
      end
    end
  endtask

  task automatic test_mismatch();
    int nk;
    logic a;
    logic [7:0] exp;
    wbuf[0] = 8'($urandom);
    wr_txn(8'h30, 1, nk); m_write(8'h30, 1);
    bus_start();
    put_byte(8'hA2, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL mismatch_dev_ack: got %b expected 0", a); end
    put_byte(8'h30, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL mismatch_word_ack: got %b expected 0", a); end
    put_byte(~wbuf[0], a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL mismatch_data_ack: got %b expected 0", a); end
    bus_stop();
    rd_txn(8'h30, 1'b1, 1, nk);
    ptr_m = 8'h30;
    exp = m_read();
    checks++;
    if (rbuf[0] !== exp || nk != 0) begin
      failures++; $display("FAIL mismatch_mem: got %h (nacks %0d) expected %h", rbuf[0], nk, exp);
    end
  endtask

  task automatic test_abort();
    int nk;
    logic a;
    logic [7:0] exp;
    wbuf[0] = 8'($urandom_range(0, 8'hEF));
    wr_txn(8'h20, 1, nk); m_write(8'h20, 1);
    bus_start();
    put_byte(8'hA0, a);
    put_byte(8'h20, a);
    put_bits(1'b1, 4);
    bus_stop();
    rd_txn(8'h20, 1'b1, 1, nk);
    ptr_m = 8'h20;
    exp = m_read();
    checks++;
    if (nk != 0) begin failures++; $display("FAIL abort_next_start: missing %0d expected 0", nk); end
    checks++;
    if (rbuf[0] !== exp) begin failures++; $display("FAIL abort_mem: got %h expected %h", rbuf[0], exp); end
  endtask

  task automatic test_reset_mid_read();
    int nk;
    logic a;
    logic [7:0] exp;
    wbuf[0] = 8'($urandom_range(0, 127));
    wr_txn(8'h40, 1, nk); m_write(8'h40, 1);
    bus_start();
    put_byte(8'hA0, a);
    put_byte(8'h40, a);
    bus_start();
    put_byte(8'hA1, a);
    checks++;
    if (sda_oe !== 1'b1) begin failures++; $display("FAIL midread_drive0: got %b expected 1", sda_oe); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL midread_async_rst: got %b expected 0", sda_oe); end
    scl = 1'b1; m_sda = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    ptr_m = 0;
    wait_clks(5);
    rd_txn(8'h00, 1'b0, 1, nk);
    exp = m_read();
    checks++;
    if (rbuf[0] !== exp || nk != 0) begin
      failures++; $display("FAIL midread_ptr0_read: got %h (nacks %0d) expected %h", rbuf[0], nk, exp);
    end
  endtask

  task automatic test_back_to_back();
    int nk, n;
    logic [7:0] addr, exp;
    bit k, cur;
    for (int it = 0; it < 10; it++) begin
      addr = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(addr, n, nk);
      m_write(int'(addr), n);
      checks++;
      if (nk != 0) begin failures++; $display("FAIL rand_write%0d_acks: missing %0d expected 0", it, nk); end
      cur = $urandom_range(0, 1) == 1;
      if (!cur) ptr_m = int'(addr);
      rd_txn(addr, !cur, n, nk);
      checks++;
      if (nk != 0) begin failures++; $display("FAIL rand_read%0d_acks: missing %0d expected 0", it, nk); end
      for (int i = 0; i < n; i++) begin
        k = known[ptr_m];
        exp = m_read();
        if (k) begin
          checks++;
          if (rbuf[i] !== exp) begin
            failures++; $display("FAIL rand%0d_byte%0d: got %h expected %h", it, i, rbuf[i], exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_seq_wrap();
    test_page_wrap();
    test_mismatch();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C slave that emulates a small serial EEPROM (24C02-style, 8-bit word address) on a shared open-drain SCL/SDA bus.
- Serves as the board-level I2C target that the SoC's I2C master writes and reads in system simulation.
- Oversamples SCL/SDA on the system clock and drives SDA low only through an output-enable.

Parameters:
- ADDRESS, 7'b1010000, 7-bit device address the slave responds to.
- MEM_DEPTH, 256, number of bytes; the word pointer is 8 bits and wraps at MEM_DEPTH-1.
- PAGE_SIZE, 16, write-page size in bytes; must be a power of two.

Ports:
- clk  in  1  system clock; frequency must be at least 8x the SCL frequency.
- rst  in  1  asynchronous reset, active high.
- scl_i  in  1  sampled SCL bus level.
- sda_i  in  1  sampled SDA bus level.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release SDA (bus pull-up gives 1). There is no SCL output; the slave never stretches the clock.

Behaviour:
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchronizer, then a previous-value register for edge detection.
  - All decisions use the synchronized values.
- Bus conditions (evaluated when SCL is high):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START or STOP takes priority over any data edge in the same cycle.
- States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- Timing rules:
  - Data bits are sampled on SCL rising edges, MSB first, with a 3-bit bit counter.
  - sda_oe_o changes only on SCL falling edges, within 3 clk cycles after the edge (synchronizer latency).
- START from any state → DEV_ADDR, bit counter cleared, sda_oe_o=0. A repeated START keeps the word pointer.
- STOP from any state → IDLE with sda_oe_o=0. A partially received byte is discarded and never written.
- DEV_ADDR, after 8 bits:
  - If bits[7:1]==ADDRESS: on the next SCL fall assert sda_oe_o (ACK) and go to DEV_ACK.
  - Otherwise: no ACK, go to IDLE and ignore traffic until the next START.
- DEV_ACK: release SDA on the SCL fall that ends the 9th clock. Then:
  - R/W=0 → WORD_ADDR.
  - R/W=1 → RD_DATA, and SDA drives bit7 of mem[ptr] on that same fall (sda_oe_o = ~bit).
- WORD_ADDR: after 8 bits, ptr := byte; ACK, then WORD_ACK → WR_DATA.
- WR_DATA: after 8 bits, mem[ptr] := byte; ACK (WR_ACK).
  - The pointer increments within its page only: ptr := {ptr[7:log2 PAGE_SIZE], (ptr+1) low bits}.
  - Further bytes continue in WR_DATA.
- RD_DATA:
  - Shift out mem[ptr] MSB first, changing on SCL falls.
  - After the 8th bit, release SDA for the master ACK slot (RD_ACK).
- RD_ACK: sample SDA on the 9th SCL rise.
  - 0 (ACK): ptr := ptr+1, wrapping MEM_DEPTH-1→0; return to RD_DATA and present the next byte's MSB on the next SCL fall.
  - 1 (NACK): go to IDLE.
- Write timing: there is no internal write cycle, so a written byte is readable immediately.
- Reset:
  - Forces IDLE, sda_oe_o=0, ptr=0, bit counter=0, synchronizer flops=1 (idle bus).
  - Memory contents are not reset. Reset mid-transfer releases SDA immediately (asynchronous).
- The slave never drives SDA while SCL is high, except that it holds an ACK or data bit stable through the high phase.

Test Plan:
- Reset, then write: START, 0xA0 (ACK), word addr 0x10 (ACK), data 0x5A (ACK), STOP. Then START, 0xA0, 0x10, repeated START, 0xA1 → slave returns 0x5A; master NACK; STOP → sda_oe_o=0, state IDLE.
- Sequential read wrap: preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33. Set ptr 0xFE, read 3 bytes with ACK, ACK, NACK → 0x11, 0x22, 0x33.
- Page-write wrap: write 0xAA, 0xBB starting at word 0x0F → mem[0x0F]=0xAA, mem[0x00]=0xBB, mem[0x10] unchanged.
- Address mismatch: START, 0xA2 → no ACK on 9th clock (sda_oe_o stays 0); following bytes ignored; memory unchanged.
- Aborted write: START, 0xA0, 0x20, then 4 data bits of 0xFF, then STOP → mem[0x20] unchanged; next START is accepted normally.
- Reset mid-read: assert rst while the slave drives a 0 data bit → sda_oe_o=0 within the same cycle; after release, a fresh write/read works with ptr starting at 0.
